// File: rtl/hls_txn_profiler.sv
// Per-channel transaction profiler for HLS ap_ctrl_hs / ap_ctrl_chain handshakes.
// Optional stall-cycle counters are built when HLS_TXN_PROFILER_STALL_EN is defined.
module hls_txn_profiler #(
  parameter int N_CH    = 4,
  parameter int MAX_OUT = 4,
  parameter int TS_W    = 32,
  parameter int CNT_W   = 32,
  localparam int RD_W   = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [N_CH-1:0]   ap_start,
  input  logic [N_CH-1:0]   ap_ready,
  input  logic [N_CH-1:0]   ap_done,
  input  logic [N_CH-1:0]   ap_continue,
  input  logic              finish,
  input  logic              clear,
  input  logic [RD_W-1:0]   rd_ch,
  input  logic [2:0]        rd_sel,
  output logic [CNT_W-1:0]  rd_data,
  output logic [N_CH-1:0]   busy,
  output logic              err
);

  // state | meaning
  // IDLE  | no transaction in flight (occupancy 0)
  // BUSY  | at least one start timestamp waiting for its done
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  localparam int PTR_W = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
  localparam int OCC_W = $clog2(MAX_OUT + 1);
  localparam int N_RD  = 2 ** RD_W;

  logic [TS_W-1:0]  ts_q;
  logic [CNT_W-1:0] rd_data_q;
  logic [CNT_W-1:0] fld_w [N_RD];
  logic [N_CH-1:0]  flag_w;
  logic [N_CH-1:0]  busy_w;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ts_q      <= '0;
      rd_data_q <= '0;
    end else if (clear) begin
      ts_q      <= '0;
      rd_data_q <= '0;
    end else begin
      ts_q      <= ts_q + TS_W'(1);
      rd_data_q <= fld_w[rd_ch];
    end
  end

  assign rd_data = rd_data_q;
  assign busy    = busy_w;
  assign err     = |flag_w;

  for (genvar e = N_CH; e < N_RD; e++) begin : g_pad
    assign fld_w[e] = '0;
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    logic [TS_W-1:0]  mem_q [MAX_OUT];
    logic [PTR_W-1:0] rp_q, rp_d, wp_q, wp_d;
    logic [OCC_W-1:0] occ_q, occ_d;
    logic             armed_q, armed_d, started_q, started_d;
    logic             ovf_q, ovf_d, udf_q, udf_d;
    logic [0:0]       state_q, state_d;
    logic [TS_W-1:0]  last_start_q, last_start_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, min_q, min_d, max_q, max_d;
    logic [CNT_W-1:0] last_q, last_d, ivl_q, ivl_d;
    logic             st_w, dn_w, empty_w, full_w, bypass_w, pop_w, push_w;
    logic [TS_W-1:0]  head_w, lat_ts_w, gap_w;
    logic [CNT_W-1:0] lat_w, stall_w, fld_c;

    assign st_w     = ap_start[g] & armed_q & ~finish;
    assign dn_w     = ap_done[g] & ap_continue[g] & ~finish;
    assign empty_w  = (occ_q == '0);
    assign full_w   = (occ_q == OCC_W'(MAX_OUT));
    assign bypass_w = st_w & dn_w & empty_w;
    assign pop_w    = dn_w & ~empty_w;
    assign push_w   = st_w & ~bypass_w & (~full_w | pop_w);
    // A bypassed transaction measures against the current timestamp, giving latency 1.
    assign head_w   = bypass_w ? ts_q : mem_q[rp_q];
    assign lat_ts_w = ts_q - head_w + TS_W'(1);
    assign lat_w    = lat_ts_w[CNT_W-1:0];
    assign gap_w    = ts_q - last_start_q;

    always_comb begin
      armed_d      = armed_q;
      started_d    = started_q;
      last_start_d = last_start_q;
      ivl_d        = ivl_q;
      rp_d         = rp_q;
      wp_d         = wp_q;
      occ_d        = occ_q;
      cnt_d        = cnt_q;
      min_d        = min_q;
      max_d        = max_q;
      last_d       = last_q;
      ovf_d        = ovf_q;
      udf_d        = udf_q;
      if (st_w) begin
        armed_d      = 1'b0;
        started_d    = 1'b1;
        last_start_d = ts_q;
        ivl_d        = started_q ? gap_w[CNT_W-1:0] : '0;
      end
      if (ap_start[g] & ap_ready[g] & ~finish) armed_d = 1'b1;
      if (push_w) wp_d = (wp_q == PTR_W'(MAX_OUT - 1)) ? '0 : wp_q + PTR_W'(1);
      if (pop_w)  rp_d = (rp_q == PTR_W'(MAX_OUT - 1)) ? '0 : rp_q + PTR_W'(1);
      case ({push_w, pop_w})
        2'b10:   occ_d = occ_q + OCC_W'(1);
        2'b01:   occ_d = occ_q - OCC_W'(1);
        default: occ_d = occ_q;
      endcase
      if (pop_w | bypass_w) begin
        cnt_d  = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
        last_d = lat_w;
        if (lat_w < min_q) min_d = lat_w;
        if (lat_w > max_q) max_d = lat_w;
      end
      if (st_w & full_w & ~pop_w) ovf_d = 1'b1;
      if (dn_w & empty_w & ~st_w) udf_d = 1'b1;
      state_d = (occ_d != '0) ? ST_BUSY : ST_IDLE;
    end

    always_ff @(posedge clock) begin
      if (push_w & ~clear) mem_q[wp_q] <= ts_q;
    end

    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        armed_q <= 1'b1;  started_q <= 1'b0;  last_start_q <= '0;  ivl_q <= '0;
        rp_q    <= '0;    wp_q      <= '0;    occ_q        <= '0;
        cnt_q   <= '0;    min_q     <= '1;    max_q        <= '0;  last_q <= '0;
        ovf_q   <= 1'b0;  udf_q     <= 1'b0;  state_q      <= ST_IDLE;
      end else if (clear) begin
        armed_q <= 1'b1;  started_q <= 1'b0;  last_start_q <= '0;  ivl_q <= '0;
        rp_q    <= '0;    wp_q      <= '0;    occ_q        <= '0;
        cnt_q   <= '0;    min_q     <= '1;    max_q        <= '0;  last_q <= '0;
        ovf_q   <= 1'b0;  udf_q     <= 1'b0;  state_q      <= ST_IDLE;
      end else begin
        armed_q <= armed_d;  started_q <= started_d;  last_start_q <= last_start_d;
        ivl_q   <= ivl_d;    rp_q      <= rp_d;       wp_q         <= wp_d;
        occ_q   <= occ_d;    cnt_q     <= cnt_d;      min_q        <= min_d;
        max_q   <= max_d;    last_q    <= last_d;     ovf_q        <= ovf_d;
        udf_q   <= udf_d;    state_q   <= state_d;
      end
    end

`ifdef HLS_TXN_PROFILER_STALL_EN
    logic [CNT_W-1:0] stall_q, stall_d;
    // Backpressure: done is presented but downstream withholds ap_continue.
    assign stall_d = (ap_done[g] & ~ap_continue[g] & ~finish & (stall_q != '1))
                     ? stall_q + CNT_W'(1) : stall_q;
    assign stall_w = stall_q;

    always_ff @(posedge clock or posedge reset) begin
      if (reset)      stall_q <= '0;
      else if (clear) stall_q <= '0;
      else            stall_q <= stall_d;
    end
`else
    assign stall_w = '0;
`endif

    always_comb begin
      fld_c = '0;
      case (rd_sel)
        3'd0:    fld_c = cnt_q;
        3'd1:    fld_c = min_q;
        3'd2:    fld_c = max_q;
        3'd3:    fld_c = last_q;
        3'd4:    fld_c = ivl_q;
        3'd5:    fld_c = CNT_W'({ovf_q, udf_q, occ_q});
        3'd6:    fld_c = stall_w;
        default: fld_c = ts_q[CNT_W-1:0];
      endcase
    end

    assign fld_w[g]  = fld_c;
    assign flag_w[g] = ovf_q | udf_q;
    assign busy_w[g] = (state_q == ST_BUSY);
  end

endmodule

// File: tb/tb_hls_txn_profiler.sv
// Directed bench: a default-sized profiler plus a small one (MAX_OUT=2, 8-bit ts/stats)
// for overflow, timestamp wrap and saturation corners.
module tb_hls_txn_profiler;
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        finish = 1'b0;
  logic        clear = 1'b0;

  logic [3:0]  m_start = '0, m_ready = '0, m_done = '0, m_cont = '1;
  logic [1:0]  m_rd_ch = '0;
  logic [2:0]  m_rd_sel = '0;
  logic [31:0] m_rd_data;
  logic [3:0]  m_busy;
  logic        m_err;

  logic [2:0]  s_start = '0, s_ready = '0, s_done = '0, s_cont = '1;
  logic [1:0]  s_rd_ch = '0;
  logic [2:0]  s_rd_sel = '0;
  logic [7:0]  s_rd_data;
  logic [2:0]  s_busy;
  logic        s_err;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  typedef struct {
    int          ch;
    int          sel;
    logic [31:0] exp;
  } vec_t;
  vec_t tbl[21];

  hls_txn_profiler dut_m (
    .clock(clock), .reset(reset), .ap_start(m_start), .ap_ready(m_ready),
    .ap_done(m_done), .ap_continue(m_cont), .finish(finish), .clear(clear),
    .rd_ch(m_rd_ch), .rd_sel(m_rd_sel), .rd_data(m_rd_data), .busy(m_busy), .err(m_err)
  );

  hls_txn_profiler #(.N_CH(3), .MAX_OUT(2), .TS_W(8), .CNT_W(8)) dut_s (
    .clock(clock), .reset(reset), .ap_start(s_start), .ap_ready(s_ready),
    .ap_done(s_done), .ap_continue(s_cont), .finish(finish), .clear(clear),
    .rd_ch(s_rd_ch), .rd_sel(s_rd_sel), .rd_data(s_rd_data), .busy(s_busy), .err(s_err)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
    cyc++;
  endtask

  task automatic upto(input int n);
    while (cyc < n) tick();
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic mrd(input int ch, input int sel, input logic [31:0] exp, input string nm);
    m_rd_ch  = ch[1:0];
    m_rd_sel = sel[2:0];
    tick();
    chk(nm, m_rd_data, exp);
  endtask

  task automatic srd(input int ch, input int sel, input logic [31:0] exp, input string nm);
    s_rd_ch  = ch[1:0];
    s_rd_sel = sel[2:0];
    tick();
    chk(nm, {24'b0, s_rd_data}, exp);
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    cyc = 0;
  endtask

  int stall_exp;

  initial begin
`ifdef HLS_TXN_PROFILER_STALL_EN
    stall_exp = 7;
`else
    stall_exp = 0;
`endif
    tbl[0]  = '{0, 0, 32'd1};  tbl[1]  = '{0, 1, 32'd5};  tbl[2]  = '{0, 2, 32'd5};
    tbl[3]  = '{0, 3, 32'd5};  tbl[4]  = '{0, 4, 32'd0};  tbl[5]  = '{0, 5, 32'd0};
    tbl[6]  = '{1, 0, 32'd3};  tbl[7]  = '{1, 1, 32'd6};  tbl[8]  = '{1, 2, 32'd6};
    tbl[9]  = '{1, 3, 32'd6};  tbl[10] = '{1, 4, 32'd1};  tbl[11] = '{1, 5, 32'd0};
    tbl[12] = '{2, 0, 32'd1};  tbl[13] = '{2, 1, 32'd1};  tbl[14] = '{2, 2, 32'd1};
    tbl[15] = '{2, 4, 32'd0};  tbl[16] = '{2, 5, 32'd0};  tbl[17] = '{3, 0, 32'd0};
    tbl[18] = '{3, 1, 32'hFFFF_FFFF}; tbl[19] = '{3, 5, 32'd0}; tbl[20] = '{0, 6, 32'd0};

    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    cyc = 0;
    chk("rst_busy", {28'b0, m_busy}, 32'd0);
    chk("rst_err", {31'b0, m_err}, 32'd0);
    chk("rst_rd_data", m_rd_data, 32'd0);
    chk("rst_s_busy", {29'b0, s_busy}, 32'd0);

    // ch0: start at ts 10, held until ready+done at ts 14
    upto(10);
    m_start[0] = 1'b1;
    tick();
    chk("a_busy_on", {31'b0, m_busy[0]}, 32'd1);
    upto(14);
    m_ready[0] = 1'b1;
    m_done[0]  = 1'b1;
    tick();
    m_start[0] = 1'b0; m_ready[0] = 1'b0; m_done[0] = 1'b0;
    chk("a_busy_off", {31'b0, m_busy[0]}, 32'd0);

    // ch1: II=1 pipeline, starts 20..22, dones 25..27
    upto(20);
    m_start[1] = 1'b1; m_ready[1] = 1'b1;
    upto(23);
    m_start[1] = 1'b0; m_ready[1] = 1'b0;
    mrd(1, 5, 32'd3, "b_occ_peak");
    chk("b_busy", {31'b0, m_busy[1]}, 32'd1);
    upto(25);
    m_done[1] = 1'b1;
    upto(28);
    m_done[1] = 1'b0;
    chk("b_busy_off", {31'b0, m_busy[1]}, 32'd0);

    // ch2: bypass, then the same stimulus while frozen
    upto(30);
    m_start[2] = 1'b1; m_ready[2] = 1'b1; m_done[2] = 1'b1;
    tick();
    m_start[2] = 1'b0; m_ready[2] = 1'b0; m_done[2] = 1'b0;
    chk("c_busy", {31'b0, m_busy[2]}, 32'd0);
    upto(32);
    finish = 1'b1;
    m_start[2] = 1'b1; m_ready[2] = 1'b1; m_done[2] = 1'b1;
    tick();
    m_start[2] = 1'b0; m_ready[2] = 1'b0; m_done[2] = 1'b0;
    mrd(2, 0, 32'd1, "c_finish_count");
    finish = 1'b0;
    chk("c_err", {31'b0, m_err}, 32'd0);

    for (int i = 0; i < 21; i++)
      mrd(tbl[i].ch, tbl[i].sel, tbl[i].exp, $sformatf("tbl%0d_ch%0d_sel%0d", i, tbl[i].ch, tbl[i].sel));

    // ch1: done held 7 cycles against backpressure, then accepted
    m_start[1] = 1'b1; m_ready[1] = 1'b1;
    tick();
    m_start[1] = 1'b0; m_ready[1] = 1'b0;
    m_done[1] = 1'b1; m_cont[1] = 1'b0;
    repeat (7) tick();
    m_cont[1] = 1'b1;
    tick();
    m_done[1] = 1'b0;
    mrd(1, 0, 32'd4, "stall_count");
    mrd(1, 6, stall_exp, "stall_cycles");

    // ch3: done with nothing in flight
    m_done[3] = 1'b1;
    tick();
    m_done[3] = 1'b0;
    chk("udf_err", {31'b0, m_err}, 32'd1);
    mrd(3, 5, 32'd8, "udf_flags");
    mrd(3, 0, 32'd0, "udf_count");

    // clear mid-transaction, and outranking a start in the same cycle
    m_start[0] = 1'b1;
    tick();
    m_start[0] = 1'b0;
    chk("clr_pre_busy", {31'b0, m_busy[0]}, 32'd1);
    m_start[1] = 1'b1;
    pulse_clear();
    m_start[1] = 1'b0;
    chk("clr_busy", {28'b0, m_busy}, 32'd0);
    chk("clr_err", {31'b0, m_err}, 32'd0);
    mrd(0, 0, 32'd0, "clr_count");
    mrd(0, 1, 32'hFFFF_FFFF, "clr_min");
    mrd(1, 6, 32'd0, "clr_stall");
    upto(5);
    mrd(0, 7, 32'd5, "clr_ts");

    // small instance: third start with two in flight is dropped
    upto(10);
    s_start[0] = 1'b1; s_ready[0] = 1'b1;
    upto(13);
    s_start[0] = 1'b0; s_ready[0] = 1'b0;
    chk("ovf_err", {31'b0, s_err}, 32'd1);
    chk("ovf_busy", {29'b0, s_busy}, 32'd1);
    srd(0, 5, 32'd10, "ovf_flags");
    s_done[1] = 1'b1;
    tick();
    s_done[1] = 1'b0;
    srd(1, 5, 32'd4, "udf_s_flags");
    srd(3, 7, 32'd0, "rd_ch_oob");

    // timestamp wrap: start at ts 250, done at ts 4
    pulse_clear();
    chk("s_clr_busy", {29'b0, s_busy}, 32'd0);
    upto(250);
    s_start[2] = 1'b1; s_ready[2] = 1'b1;
    tick();
    s_start[2] = 1'b0; s_ready[2] = 1'b0;
    upto(260);
    s_done[2] = 1'b1;
    tick();
    s_done[2] = 1'b0;
    srd(2, 3, 32'd11, "wrap_lat");
    srd(2, 0, 32'd1, "wrap_count");

    // saturation: 254 more bypassed transactions reach 255, one more stays there
    s_start[2] = 1'b1; s_ready[2] = 1'b1; s_done[2] = 1'b1;
    repeat (254) tick();
    s_start[2] = 1'b0; s_ready[2] = 1'b0; s_done[2] = 1'b0;
    srd(2, 0, 32'd255, "sat_reach");
    s_start[2] = 1'b1; s_ready[2] = 1'b1; s_done[2] = 1'b1;
    tick();
    s_start[2] = 1'b0; s_ready[2] = 1'b0; s_done[2] = 1'b0;
    srd(2, 0, 32'd255, "sat_hold");
    srd(2, 1, 32'd1, "sat_min");
    srd(2, 2, 32'd11, "sat_max");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
